// File: rtl/fb_stream_reader.sv
// Framebuffer stream reader: walks one frame in row-major order, issues pipelined RAM reads,
// and presents the returned pixels on a valid/ready stream with coordinates and markers.
module fb_stream_reader #(
    parameter int unsigned IMG_W      = 256,
    parameter int unsigned IMG_H      = 256,
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic [9:0]        pix_x,
    output logic [8:0]        pix_y,
    output logic              pix_sof,
    output logic              pix_eol
);

    localparam int unsigned NPix = IMG_W * IMG_H;
    localparam int unsigned CntW = $clog2(NPix);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    localparam logic [CntW-1:0] LastPix = CntW'(NPix - 1);
    localparam logic [9:0]      XLast   = 10'(IMG_W - 1);
    localparam logic [8:0]      YLast   = 9'(IMG_H - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   fetch_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [RD_LAT-1:0] rd_pipe_q;
    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]     count_q;
    logic [9:0]        x_q;
    logic [8:0]        y_q;

    logic [PtrW:0]     inflight;
    logic [PtrW+1:0]   credit_used;
    logic              issue, push, pop, fifo_empty, start_acc, last_out;

    // Reads in the return pipeline count against FIFO space so a push never overflows.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + {{PtrW{1'b0}}, rd_pipe_q[i]};
        end
    end

    assign credit_used = {1'b0, count_q} + {1'b0, inflight};
    assign issue       = (state_q == StFetch) && (credit_used < (PtrW+2)'(FIFO_DEPTH));
    assign push        = rd_pipe_q[RD_LAT-1];
    assign fifo_empty  = (count_q == '0);
    assign pop         = !fifo_empty && pix_ready;
    assign start_acc   = (state_q == StIdle) && start;
    assign last_out    = (x_q == XLast) && (y_q == YLast);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StFetch;
            StFetch: if (issue && fetch_cnt_q == LastPix) state_d = StDrain;
            StDrain: if (pop && last_out) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy      = (state_q == StFetch) || (state_q == StDrain);
    assign done      = (state_q == StDone);
    assign mem_rd_en = issue;
    assign mem_addr  = addr_q;
    assign pix_valid = !fifo_empty;
    assign pix_data  = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];
    assign pix_x     = x_q;
    assign pix_y     = y_q;
    assign pix_sof   = pix_valid && (x_q == '0) && (y_q == '0);
    assign pix_eol   = pix_valid && (x_q == XLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            fetch_cnt_q <= '0;
            addr_q      <= '0;
            rd_pipe_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                fetch_cnt_q <= '0;
                addr_q      <= ADDR_W'(BASE_ADDR);
            end else if (issue) begin
                fetch_cnt_q <= fetch_cnt_q + CntW'(1);
                addr_q      <= addr_q + ADDR_W'(1);
            end
            rd_pipe_q[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + (PtrW+1)'(1);
            else if (!push && pop) count_q <= count_q - (PtrW+1)'(1);
            if (start_acc) begin
                x_q <= '0;
                y_q <= '0;
            end else if (pop) begin
                if (x_q == XLast) begin
                    x_q <= '0;
                    y_q <= y_q + 9'd1;
                end else begin
                    x_q <= x_q + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= mem_rdata;
    end

endmodule

// File: tb/tb_fb_stream_reader.sv
// Directed bench for fb_stream_reader: a 4x2 frame reader plus a 4x1 reader whose base
// address sits just below the top of the address space.
module tb_fb_stream_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, pix_ready, start_w;
    logic        busy, done, mem_rd_en, pix_valid, pix_sof, pix_eol;
    logic [17:0] mem_addr;
    logic [23:0] mem_rdata, ram_p1, pix_data;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;

    logic        busy_w, done_w, mem_rd_en_w, pix_valid_w, pix_sof_w, pix_eol_w;
    logic [17:0] mem_addr_w;
    logic [23:0] mem_rdata_w, pix_data_w;
    logic [9:0]  pix_x_w;
    logic [8:0]  pix_y_w;

    fb_stream_reader #(.IMG_W(4), .IMG_H(2), .ADDR_W(18), .DATA_W(24), .BASE_ADDR(0),
                       .RD_LAT(2), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol)
    );

    fb_stream_reader #(.IMG_W(4), .IMG_H(1), .ADDR_W(18), .DATA_W(24), .BASE_ADDR(262142),
                       .RD_LAT(2), .FIFO_DEPTH(8)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .busy(busy_w), .done(done_w),
        .mem_rd_en(mem_rd_en_w), .mem_addr(mem_addr_w), .mem_rdata(mem_rdata_w),
        .pix_valid(pix_valid_w), .pix_ready(1'b1), .pix_data(pix_data_w),
        .pix_x(pix_x_w), .pix_y(pix_y_w), .pix_sof(pix_sof_w), .pix_eol(pix_eol_w)
    );

    function automatic logic [23:0] ram_word(input logic [17:0] a);
        return {6'h2b, a} ^ 24'h00a5c3;
    endfunction

    // Two-stage RAM model: data for a read in cycle N is on mem_rdata in cycle N+2.
    always @(posedge clk) begin
        ram_p1      <= mem_rd_en ? ram_word(mem_addr) : 24'h0;
        mem_rdata   <= ram_p1;
        mem_rdata_w <= 24'h0;
    end

    int cyc = 0;
    int t0  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          rd_cyc[$], px_cyc[$], done_cyc[$];
    logic [17:0] rd_addr[$], w_addr[$];
    logic [23:0] px_data[$];
    logic [9:0]  px_x[$];
    logic [8:0]  px_y[$];
    logic        px_sof[$], px_eol[$];
    int          nvalid = 0, stable_err = 0, rd_total = 0, px_total = 0, max_outst = 0;
    logic        hold_prev = 1'b0;
    logic [23:0] prev_data;
    logic [9:0]  prev_x;
    logic [8:0]  prev_y;

    always @(negedge clk) begin
        if (mem_rd_en) begin
            rd_cyc.push_back(cyc - t0);
            rd_addr.push_back(mem_addr);
            rd_total <= rd_total + 1;
        end
        if (pix_valid && pix_ready) begin
            px_cyc.push_back(cyc - t0);
            px_data.push_back(pix_data);
            px_x.push_back(pix_x);
            px_y.push_back(pix_y);
            px_sof.push_back(pix_sof);
            px_eol.push_back(pix_eol);
            px_total <= px_total + 1;
        end
        if (rd_total - px_total > max_outst) max_outst <= rd_total - px_total;
        if (pix_valid) nvalid <= nvalid + 1;
        if (done) done_cyc.push_back(cyc - t0);
        if (mem_rd_en_w) w_addr.push_back(mem_addr_w);
        if (hold_prev && pix_valid &&
            (pix_data !== prev_data || pix_x !== prev_x || pix_y !== prev_y))
            stable_err <= stable_err + 1;
        hold_prev <= pix_valid && !pix_ready;
        prev_data <= pix_data;
        prev_x    <= pix_x;
        prev_y    <= pix_y;
    end

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        rd_cyc.delete(); rd_addr.delete(); px_cyc.delete(); px_data.delete();
        px_x.delete(); px_y.delete(); px_sof.delete(); px_eol.delete();
        done_cyc.delete(); w_addr.delete();
    endtask

    task automatic start_frame();
        start = 1'b1;
        t0    = cyc;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (done_cyc.size() == 0 && n < bound) begin
            step(1);
            n++;
        end
        check_eq("done_seen", 32'(done_cyc.size() != 0), 32'd1);
        step(3);
        check_eq("done_once", 32'(done_cyc.size()), 32'd1);
    endtask

    task automatic check_pixels(input string tag);
        check_eq({tag, "_npix"}, 32'(px_data.size()), 32'd8);
        for (int k = 0; k < px_data.size() && k < 8; k++) begin
            check_eq({tag, "_data"}, 32'(px_data[k]), 32'(ram_word(18'(k))));
            check_eq({tag, "_x"}, 32'(px_x[k]), 32'(k % 4));
            check_eq({tag, "_y"}, 32'(px_y[k]), 32'(k / 4));
            check_eq({tag, "_sof"}, 32'(px_sof[k]), 32'(k == 0));
            check_eq({tag, "_eol"}, 32'(px_eol[k]), 32'(k % 4 == 3));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
        check_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, "_valid"}, 32'(pix_valid), 32'd0);
        check_eq({tag, "_data"}, 32'(pix_data), 32'd0);
        check_eq({tag, "_x"}, 32'(pix_x), 32'd0);
        check_eq({tag, "_y"}, 32'(pix_y), 32'd0);
        check_eq({tag, "_sof"}, 32'(pix_sof), 32'd0);
        check_eq({tag, "_eol"}, 32'(pix_eol), 32'd0);
    endtask

    task automatic check_nominal_frame(input string tag);
        check_eq({tag, "_nrd"}, 32'(rd_addr.size()), 32'd8);
        for (int k = 0; k < rd_addr.size() && k < 8; k++) begin
            check_eq({tag, "_rd_cyc"}, 32'(rd_cyc[k]), 32'(k + 1));
            check_eq({tag, "_rd_addr"}, 32'(rd_addr[k]), 32'(k));
        end
        for (int k = 0; k < px_cyc.size() && k < 8; k++)
            check_eq({tag, "_px_cyc"}, 32'(px_cyc[k]), 32'(k + 4));
        check_pixels(tag);
        check_eq({tag, "_ndone"}, 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() > 0) check_eq({tag, "_done_cyc"}, 32'(done_cyc[0]), 32'd12);
    endtask

    initial begin
        int nv0;
        int n;
        rst       = 1'b1;
        start     = 1'b0;
        start_w   = 1'b0;
        pix_ready = 1'b1;
        step(3);
        check_reset_outputs("rst");
        rst = 1'b0;
        step(1);

        // Free-running frame with exact cycle timing.
        clear_logs();
        start_frame();
        check_eq("busy_c1", 32'(busy), 32'd1);
        step(15);
        check_nominal_frame("run");
        check_eq("busy_idle", 32'(busy), 32'd0);

        // Sink stalled for 31 cycles: credit limit caps reads at the FIFO depth.
        clear_logs();
        pix_ready = 1'b0;
        start_frame();
        step(30);
        check_eq("stall_nrd", 32'(rd_addr.size()), 32'd8);
        check_eq("stall_npix", 32'(px_data.size()), 32'd0);
        check_eq("stall_valid", 32'(pix_valid), 32'd1);
        check_eq("stall_rd_en", 32'(mem_rd_en), 32'd0);
        pix_ready = 1'b1;
        wait_done(40);
        check_pixels("stall");
        check_eq("stall_hold", 32'(stable_err), 32'd0);

        // Random backpressure.
        clear_logs();
        start = 1'b1;
        t0    = cyc;
        n     = 0;
        while (done_cyc.size() == 0 && n < 300) begin
            pix_ready = 1'($urandom_range(0, 1));
            step(1);
            start = 1'b0;
            n++;
        end
        pix_ready = 1'b1;
        check_eq("rand_done_seen", 32'(done_cyc.size()), 32'd1);
        step(2);
        check_pixels("rand");
        check_eq("rand_nrd", 32'(rd_addr.size()), 32'd8);
        check_eq("max_outstanding_le8", 32'(max_outst <= 8), 32'd1);
        check_eq("rand_hold", 32'(stable_err), 32'd0);

        // Second start while busy is ignored; start right after done opens a new frame.
        clear_logs();
        start_frame();
        step(2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(9);
        check_eq("dbl_nrd", 32'(rd_addr.size()), 32'd8);
        check_eq("dbl_ndone", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() > 0) check_eq("dbl_done_cyc", 32'(done_cyc[0]), 32'd12);
        check_eq("dbl_idle", 32'(busy), 32'd0);
        clear_logs();
        start_frame();
        step(15);
        check_nominal_frame("b2b");

        // Reset mid-frame with reads in flight.
        clear_logs();
        start_frame();
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_reset_outputs("midrst");
        nv0 = nvalid;
        step(10);
        check_eq("midrst_no_valid", 32'(nvalid - nv0), 32'd0);
        clear_logs();
        start_frame();
        step(15);
        check_nominal_frame("postrst");

        // Address wrap at the top of the 18-bit space.
        clear_logs();
        start_w = 1'b1;
        step(1);
        start_w = 1'b0;
        step(12);
        check_eq("wrap_nrd", 32'(w_addr.size()), 32'd4);
        if (w_addr.size() == 4) begin
            check_eq("wrap_a0", 32'(w_addr[0]), 32'h3fffe);
            check_eq("wrap_a1", 32'(w_addr[1]), 32'h3ffff);
            check_eq("wrap_a2", 32'(w_addr[2]), 32'h00000);
            check_eq("wrap_a3", 32'(w_addr[3]), 32'h00001);
        end
        check_eq("wrap_idle", 32'(busy_w), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
